// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// the canonical quiet-NaN pattern used by the arithmetic pipelines.
package fp_pkg;

    // Operand classification after flush-to-zero of subnormals
    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    // Bit positions inside the 4-bit {invalid, overflow, underflow, inexact} vector
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    // Widest word the helper below can describe
    localparam int FP_MAX_W = 128;

    // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set, rest zero
    function automatic logic [FP_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) begin
            r[man_w+i] = 1'b1;
        end
        r[man_w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a truncated mantissa. Purely combinational so it
// can sit inside any pipeline stage (multiplier now, adder later).
module fp_round_rne #(
    parameter int MAN_W = 23
) (
    input  logic [MAN_W-1:0] i_man,
    input  logic             i_guard,
    input  logic             i_sticky,
    output logic [MAN_W-1:0] o_man,
    output logic             o_carry,
    output logic             o_inexact
);

    logic           w_up;
    logic [MAN_W:0] w_sum;

    // Exact ties go to the even neighbour, so the kept LSB breaks the tie
    assign w_up      = i_guard & (i_sticky | i_man[0]);
    assign w_sum     = {1'b0, i_man} + {{MAN_W{1'b0}}, w_up};
    // A carry out means the mantissa wrapped to zero and the exponent must step
    assign o_man     = w_sum[MAN_W-1:0];
    assign o_carry   = w_sum[MAN_W];
    assign o_inexact = i_guard | i_sticky;

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined IEEE-754 multiplier with valid/ready handshake, RNE,
// flush-to-zero, special-value handling and a per-result flag vector.
// Optional build macro FP_MUL_STICKY_FLAGS_EN adds an accumulating sticky
// flag register; without it the sticky port is tied to zero.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    parameter  int TAG_W = 4,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic [3:0]       sticky
);

    localparam int PW = 2*MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS     = EW'((2**(EXP_W-1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((2**EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0]         QNAN_WORD = W'(canon_qnan(EXP_W, MAN_W));

    // Exponent field zero means zero or subnormal, both flushed to zero
    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return ZERO;
        if (e == '1) begin
            if (m == '0) return INF;
            if (m[MAN_W-1]) return QNAN;
            return SNAN;
        end
        return NORM;
    endfunction

    // ---------------- handshake ----------------
    logic w_stall;
    logic w_adv;
    logic r_vld_p0, r_vld_p1, r_vld_p2;

    assign w_stall   = r_vld_p2 & ~out_ready;
    assign w_adv     = ~w_stall;
    assign in_ready  = ~w_stall;
    assign out_valid = r_vld_p2;

    // Valid bits shift together; everything freezes while the output is blocked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p0 <= in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // ---------------- S1: unpack, classify, exponent sum, mantissa product ----------------
    logic                 w_sign;
    fp_class_e            w_cls_a, w_cls_b;
    logic signed [EW-1:0] w_esum;
    logic [PW-1:0]        w_prod;

    assign w_sign  = in_a[W-1] ^ in_b[W-1];
    assign w_cls_a = classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
    assign w_cls_b = classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
    assign w_esum  = $signed({2'b00, in_a[W-2:MAN_W]}) + $signed({2'b00, in_b[W-2:MAN_W]}) - BIAS;
    assign w_prod  = {{(MAN_W+1){1'b0}}, 1'b1, in_a[MAN_W-1:0]}
                   * {{(MAN_W+1){1'b0}}, 1'b1, in_b[MAN_W-1:0]};

    logic                 r_sign_p0;
    fp_class_e            r_cls_a_p0, r_cls_b_p0;
    logic signed [EW-1:0] r_esum_p0;
    logic [PW-1:0]        r_prod_p0;
    logic [TAG_W-1:0]     r_tag_p0;

    // S1 data register (no reset: qualified by r_vld_p0)
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sign_p0  <= w_sign;
            r_cls_a_p0 <= w_cls_a;
            r_cls_b_p0 <= w_cls_b;
            r_esum_p0  <= w_esum;
            r_prod_p0  <= w_prod;
            r_tag_p0   <= in_tag;
        end
    end

    // ---------------- S2: normalise, guard/sticky, RNE ----------------
    logic                 w_norm;
    logic [MAN_W-1:0]     w_frac;
    logic                 w_guard;
    logic                 w_sticky;
    logic [MAN_W-1:0]     w_man_rnd;
    logic                 w_carry;
    logic                 w_inexact;
    logic signed [EW-1:0] w_exp_n;
    logic signed [EW-1:0] w_exp_r;

    // Product is in [1,4): when the top bit is set the binary point moves one place
    assign w_norm = r_prod_p0[PW-1];

    // Pick the kept fraction and the first dropped bit / OR of the rest
    always_comb begin
        if (w_norm) begin
            w_frac   = r_prod_p0[PW-2:MAN_W+1];
            w_guard  = r_prod_p0[MAN_W];
            w_sticky = |r_prod_p0[MAN_W-1:0];
        end else begin
            w_frac   = r_prod_p0[PW-3:MAN_W];
            w_guard  = r_prod_p0[MAN_W-1];
            w_sticky = |r_prod_p0[MAN_W-2:0];
        end
    end

    fp_round_rne #(.MAN_W(MAN_W)) u_round (
        .i_man     (w_frac),
        .i_guard   (w_guard),
        .i_sticky  (w_sticky),
        .o_man     (w_man_rnd),
        .o_carry   (w_carry),
        .o_inexact (w_inexact)
    );

    assign w_exp_n = r_esum_p0 + $signed({{(EW-1){1'b0}}, w_norm});
    assign w_exp_r = w_exp_n + $signed({{(EW-1){1'b0}}, w_carry});

    logic                 r_sign_p1;
    fp_class_e            r_cls_a_p1, r_cls_b_p1;
    logic signed [EW-1:0] r_exp_p1;
    logic [MAN_W-1:0]     r_man_p1;
    logic                 r_inx_p1;
    logic [TAG_W-1:0]     r_tag_p1;

    // S2 data register
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sign_p1  <= r_sign_p0;
            r_cls_a_p1 <= r_cls_a_p0;
            r_cls_b_p1 <= r_cls_b_p0;
            r_exp_p1   <= w_exp_r;
            r_man_p1   <= w_man_rnd;
            r_inx_p1   <= w_inexact;
            r_tag_p1   <= r_tag_p0;
        end
    end

    // ---------------- S3: special-case select, range check, pack ----------------
    logic         w_nan_in, w_snan_in, w_inf_in, w_zero_in, w_inf_zero;
    logic [W-1:0] w_res;
    logic [3:0]   w_flags;

    assign w_snan_in  = (r_cls_a_p1 == SNAN) | (r_cls_b_p1 == SNAN);
    assign w_nan_in   = w_snan_in | (r_cls_a_p1 == QNAN) | (r_cls_b_p1 == QNAN);
    assign w_inf_in   = (r_cls_a_p1 == INF) | (r_cls_b_p1 == INF);
    assign w_zero_in  = (r_cls_a_p1 == ZERO) | (r_cls_b_p1 == ZERO);
    assign w_inf_zero = w_inf_in & w_zero_in;

    // Priority: NaN / Inf*0, Inf, zero, then overflow, underflow, normal
    always_comb begin
        w_res   = {r_sign_p1, r_exp_p1[EXP_W-1:0], r_man_p1};
        w_flags = '0;
        if (w_nan_in || w_inf_zero) begin
            w_res            = QNAN_WORD;
            w_flags[FLG_INV] = w_inf_zero | w_snan_in;
        end else if (w_inf_in) begin
            w_res = {r_sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_zero_in) begin
            w_res = {r_sign_p1, {(W-1){1'b0}}};
        end else if (r_exp_p1 >= EXP_MAX) begin
            w_res            = {r_sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags[FLG_OVF] = 1'b1;
            w_flags[FLG_INX] = 1'b1;
        end else if (r_exp_p1 <= EXP_ZERO) begin
            w_res            = {r_sign_p1, {(W-1){1'b0}}};
            w_flags[FLG_UNF] = 1'b1;
            w_flags[FLG_INX] = 1'b1;
        end else begin
            w_flags[FLG_INX] = r_inx_p1;
        end
    end

    logic [W-1:0]     r_res_p2;
    logic [TAG_W-1:0] r_tag_p2;
    logic [3:0]       r_flags_p2;

    // Output register, cleared by reset and held while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_p2   <= '0;
            r_tag_p2   <= '0;
            r_flags_p2 <= '0;
        end else if (w_adv) begin
            r_res_p2   <= w_res;
            r_tag_p2   <= r_tag_p1;
            r_flags_p2 <= w_flags;
        end
    end

    assign out_res   = r_res_p2;
    assign out_tag   = r_tag_p2;
    assign out_flags = r_flags_p2;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [3:0] r_sticky;

    // Accumulate flags of every result the consumer actually takes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
        end else if (r_vld_p2 && out_ready) begin
            r_sticky <= r_sticky | r_flags_p2;
        end
    end

    assign sticky = r_sticky;
`else
    assign sticky = 4'b0000;
`endif

endmodule
